// File: rtl/axi_sram_responder.sv
// AXI4-style slave memory built on an internal word array of 256-bit beats.
// Write and read channels are fully independent, each holding one burst at a time.
//
// Ports:
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   s_axi_aw*             write address channel (awsize ignored, beats are 32 B)
//   s_axi_w*              write data channel with per-byte strobes
//   s_axi_b*              write response channel (no response code)
//   s_axi_ar*             read address channel (arsize ignored)
//   s_axi_r*              read data channel
//   proto_err             sticky flag: wlast disagreed with the burst length
module axi_sram_responder #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned MEM_BYTES = 2097152
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,

    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,

    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,

    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic                  s_axi_rlast,

    output logic                  proto_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned DEPTH  = MEM_BYTES / 32;
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic       {RIdle, RData}        r_state_e;

    // Storage; deliberately has no reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_e          w_state_q, w_state_d;
    logic [IDX_W-1:0]  w_base_q, w_base_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              proto_err_q, proto_err_d;

    logic              aw_hs, w_hs, w_last_beat;
    logic [IDX_W-1:0]  aw_idx;
    logic [IDX_W+7:0]  w_sum;
    logic [IDX_W-1:0]  w_idx;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign aw_idx      = s_axi_awaddr[IDX_W+4:5];
    // Wider sum then truncation gives the modulo-depth wrap for free.
    assign w_sum       = {{8{1'b0}}, w_base_q} + {{IDX_W{1'b0}}, w_cnt_q};
    assign w_idx       = w_sum[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= WIdle;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle:   if (aw_hs) w_state_d = WData;
            WData:   if (w_hs && w_last_beat) w_state_d = WResp;
            WResp:   if (s_axi_bready) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (w_state_q)
            WIdle:   s_axi_awready = 1'b1;
            WData:   s_axi_wready  = 1'b1;
            WResp:   s_axi_bvalid  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_base_d    = w_base_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        proto_err_d = proto_err_q;
        if (aw_hs) begin
            w_base_d = aw_idx;
            w_len_d  = s_axi_awlen;
            w_cnt_d  = 8'd0;
        end else if (w_hs) begin
            w_cnt_d = w_cnt_q + 8'd1;
        end
        // Burst length is governed by awlen; a disagreeing wlast is only flagged.
        if (w_hs && (s_axi_wlast != w_last_beat)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_base_q    <= '0;
            w_len_q     <= 8'd0;
            w_cnt_q     <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            w_base_q    <= w_base_d;
            w_len_q     <= w_len_d;
            w_cnt_q     <= w_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_e          r_state_q, r_state_d;
    logic [IDX_W-1:0]  r_base_q, r_base_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic [DATA_W-1:0] rdata_q;

    logic              ar_hs, r_hs, r_last_beat, rd_en;
    logic [IDX_W-1:0]  ar_idx, rd_base;
    logic [IDX_W+7:0]  rd_sum;
    logic [IDX_W-1:0]  rd_idx;

    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign r_hs        = s_axi_rvalid && s_axi_rready;
    assign r_last_beat = (r_cnt_q == r_len_q);
    assign ar_idx      = s_axi_araddr[IDX_W+4:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= RIdle;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle:   if (ar_hs) r_state_d = RData;
            RData:   if (r_hs && r_last_beat) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        unique case (r_state_q)
            RIdle:   s_axi_arready = 1'b1;
            RData: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = r_last_beat;
            end
            default: ;
        endcase
    end

    always_comb begin
        r_base_d = r_base_q;
        r_len_d  = r_len_q;
        r_cnt_d  = r_cnt_q;
        if (ar_hs) begin
            r_base_d = ar_idx;
            r_len_d  = s_axi_arlen;
            r_cnt_d  = 8'd0;
        end else if (r_hs) begin
            r_cnt_d = r_cnt_q + 8'd1;
        end
    end

    // Fetch the beat that will be on the bus next cycle: the first beat on AR,
    // the following beat on each non-final R handshake. Otherwise rdata holds.
    assign rd_en   = ar_hs || (r_hs && !r_last_beat);
    assign rd_base = ar_hs ? ar_idx : r_base_q;
    assign rd_sum  = {{8{1'b0}}, rd_base} + {{IDX_W{1'b0}}, r_cnt_d};
    assign rd_idx  = rd_sum[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_q <= '0;
            r_len_q  <= 8'd0;
            r_cnt_q  <= 8'd0;
        end else begin
            r_base_q <= r_base_d;
            r_len_q  <= r_len_d;
            r_cnt_q  <= r_cnt_d;
        end
    end

    // Non-blocking read alongside the write block yields pre-write data on a
    // same-word collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end

    assign s_axi_rdata = rdata_q;

    // Address offset bits, aliased upper bits and size codes carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[ADDR_W-1:IDX_W+5], s_axi_awaddr[4:0],
                           s_axi_araddr[ADDR_W-1:IDX_W+5], s_axi_araddr[4:0],
                           s_axi_awsize, s_axi_arsize,
                           w_sum[IDX_W+7:IDX_W], rd_sum[IDX_W+7:IDX_W]};

endmodule

// File: tb/tb_axi_sram_responder.sv
// Self-checking bench for axi_sram_responder. Two instances share all inputs:
// a 2 KiB one (64 words) and a 64 B one (2 words) for the wrap/alias behaviour.
module tb_axi_sram_responder;

    localparam int unsigned DEPTH0 = 64;
    localparam int unsigned DEPTH1 = 2;

    logic         clk, rst_n;
    logic         awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [63:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [255:0] wdata;
    logic [31:0]  wstrb;

    logic         awready, wready, bvalid, arready, rvalid, rlast, proto_err;
    logic [255:0] rdata;
    logic         awready_s, wready_s, bvalid_s, arready_s, rvalid_s, rlast_s, proto_err_s;
    logic [255:0] rdata_s;

    axi_sram_responder #(.ADDR_W(64), .DATA_W(256), .MEM_BYTES(2048)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rlast(rlast), .proto_err(proto_err)
    );

    axi_sram_responder #(.ADDR_W(64), .DATA_W(256), .MEM_BYTES(64)) u_dut_small (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready_s), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready_s), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid_s), .s_axi_bready(bready),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready_s), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_rvalid(rvalid_s), .s_axi_rready(rready), .s_axi_rdata(rdata_s),
        .s_axi_rlast(rlast_s), .proto_err(proto_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: word contents plus per-byte "has been written" flags.
    logic [255:0] mdl0 [DEPTH0];
    logic [31:0]  kn0  [DEPTH0];
    logic [255:0] mdl1 [DEPTH1];
    logic [31:0]  kn1  [DEPTH1];

    logic [255:0] wbuf  [256];
    logic [31:0]  sbuf  [256];
    logic [255:0] rcap  [256];
    logic [255:0] rcap1 [256];
    int           rd_hs;

    typedef struct {
        logic [63:0]  waddr;
        logic [255:0] wdata;
        logic [31:0]  wstrb;
        logic [63:0]  raddr;
        logic [255:0] exp;
    } vec_t;
    vec_t vecs [5];

    task automatic chk1(input string name, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, got, exp);
    endtask

    task automatic chkw(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic int unsigned widx(input logic [63:0] addr, input int beat,
                                         input int unsigned depth);
        return int'(((addr >> 5) + 64'(beat)) % 64'(depth));
    endfunction

    function automatic logic [255:0] bmask(input logic [31:0] k);
        logic [255:0] m;
        m = '0;
        for (int j = 0; j < 32; j++) if (k[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic mdl_write(input logic [63:0] addr, input int beat,
                             input logic [255:0] d, input logic [31:0] s);
        int unsigned i0, i1;
        i0 = widx(addr, beat, DEPTH0);
        i1 = widx(addr, beat, DEPTH1);
        for (int j = 0; j < 32; j++) begin
            if (s[j]) begin
                mdl0[i0][8*j +: 8] = d[8*j +: 8];
                kn0[i0][j] = 1'b1;
                mdl1[i1][8*j +: 8] = d[8*j +: 8];
                kn1[i1][j] = 1'b1;
            end
        end
    endtask

    task automatic check_reset();
        chk1("rst_awready", awready, 1'b1);
        chk1("rst_arready", arready, 1'b1);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_rlast", rlast, 1'b0);
        chkw("rst_rdata", rdata, '0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chkw("rst_rdata_small", rdata_s, '0);
    endtask

    // Write burst from wbuf/sbuf. bad_last >= 0 puts wlast on that beat instead
    // of the final one; abort_after >= 0 stops after that beat's handshake.
    task automatic wr_burst(input logic [63:0] addr, input int len, input int bad_last,
                            input int abort_after, input bit gaps);
        int t;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
        t = 0;
        while (!awready && t < 200) begin @(negedge clk); t++; end
        chk1("aw_accept", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        chk1("awready_busy", awready, 1'b0);
        for (int b = 0; b <= len; b++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b];
            wlast  = (bad_last >= 0) ? (b == bad_last) : (b == len);
            chk1("wready_beat", wready, 1'b1);
            mdl_write(addr, b, wbuf[b], sbuf[b]);
            @(negedge clk);
            if (b == abort_after) begin wvalid = 1'b0; wlast = 1'b0; return; end
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk1("bvalid_after_last", bvalid, 1'b1);
        chk1("wready_after_last", wready, 1'b0);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk1("bvalid_hold", bvalid, 1'b1);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk1("bvalid_single", bvalid, 1'b0);
        chk1("awready_after_b", awready, 1'b1);
    endtask

    // mode 0: rready always 1; 1: pattern 1,0,0 repeating; 2: random.
    task automatic rd_burst(input logic [63:0] addr, input int len, input int mode);
        int t, b, cyc;
        int unsigned i0, i1;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; arlen = 8'(len);
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        chk1("ar_accept", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        b = 0; cyc = 0;
        while (b <= len && cyc < 2000) begin
            i0 = widx(addr, b, DEPTH0);
            i1 = widx(addr, b, DEPTH1);
            chk1("rvalid", rvalid, 1'b1);
            chk1("arready_busy", arready, 1'b0);
            chk1("rlast", rlast, b == len);
            if (kn0[i0] != 0)
                chkw("rdata", rdata & bmask(kn0[i0]), mdl0[i0] & bmask(kn0[i0]));
            if (kn1[i1] != 0)
                chkw("rdata_small", rdata_s & bmask(kn1[i1]), mdl1[i1] & bmask(kn1[i1]));
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rready && rvalid) begin
                rcap[b]  = rdata;
                rcap1[b] = rdata_s;
                b++;
            end
            cyc++;
            @(negedge clk);
        end
        rready = 1'b0;
        rd_hs = b;
        chk1("rvalid_end", rvalid, 1'b0);
        chk1("arready_end", arready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish within 50000 cycles");
        $fatal(1);
    end

    initial begin
        logic [255:0] a0, a1;

        vecs[0] = '{64'h60, {32{8'hFF}}, 32'hFFFF_FFFF, 64'h60, {32{8'hFF}}};
        vecs[1] = '{64'h60, 256'h0, 32'h0000_000F, 64'h60, {{28{8'hFF}}, 32'h0}};
        vecs[2] = '{64'h40, {8{32'hDEAD_BEEF}}, 32'hFFFF_FFFF, 64'h5F, {8{32'hDEAD_BEEF}}};
        vecs[3] = '{64'h840, {32{8'h11}}, 32'hF000_0000, 64'h40,
                    {32'h1111_1111, {7{32'hDEAD_BEEF}}}};
        vecs[4] = '{64'hFFFF_0000_0000_0020, {4{64'h0123_4567_89AB_CDEF}}, 32'hFFFF_FFFF,
                    64'h20, {4{64'h0123_4567_89AB_CDEF}}};

        for (int i = 0; i < int'(DEPTH0); i++) kn0[i] = '0;
        for (int i = 0; i < int'(DEPTH1); i++) kn1[i] = '0;

        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; awlen = 0; arlen = 0; awsize = 3'd5; arsize = 3'd5;
        wdata = 0; wstrb = 0;
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        // W data offered with no burst open must not be taken.
        @(negedge clk);
        wvalid = 1'b1; wdata = {8{32'hBAD0_BAD0}}; wstrb = '1; wlast = 1'b1;
        repeat (3) begin @(negedge clk); chk1("wready_no_aw", wready, 1'b0); end
        wvalid = 1'b0; wlast = 1'b0;

        // Write then read back, 8 beats.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = {8{32'hA5A5_0000 + 32'(i)}};
            sbuf[i] = '1;
        end
        wr_burst(64'h0, 7, -1, -1, 1'b0);
        rd_burst(64'h0, 7, 0);
        for (int i = 0; i < 8; i++) chkw("wr_rd_beat", rcap[i], {8{32'hA5A5_0000 + 32'(i)}});

        // Single-beat vector table: strobes, offset bits, aliasing.
        for (int i = 0; i < 5; i++) begin
            wbuf[0] = vecs[i].wdata;
            sbuf[0] = vecs[i].wstrb;
            wr_burst(vecs[i].waddr, 0, -1, -1, 1'b0);
            rd_burst(vecs[i].raddr, 0, 0);
            chkw("vec_rdata", rcap[0], vecs[i].exp);
        end

        // Back-pressure read.
        for (int i = 0; i < 4; i++) begin wbuf[i] = rand256(); sbuf[i] = '1; end
        wr_burst(64'h200, 3, -1, -1, 1'b0);
        rd_burst(64'h200, 3, 1);
        chk1("bp_handshakes", rd_hs == 4, 1'b1);
        for (int i = 0; i < 4; i++) chkw("bp_order", rcap[i], wbuf[i]);

        // Wrap past the top word in both instances.
        wbuf[0] = {8{32'hC0C0_C0C0}}; wbuf[1] = {8{32'hD1D1_D1D1}};
        sbuf[0] = '1; sbuf[1] = '1;
        wr_burst(64'h20, 1, -1, -1, 1'b0);
        rd_burst(64'h1000, 0, 0);
        chkw("alias_small_word0", rcap1[0], {8{32'hD1D1_D1D1}});
        wbuf[0] = {8{32'hE2E2_E2E2}}; wbuf[1] = {8{32'hF3F3_F3F3}};
        wr_burst(64'h7E0, 1, -1, -1, 1'b0);
        rd_burst(64'h0, 0, 0);
        chkw("wrap_word0", rcap[0], {8{32'hF3F3_F3F3}});

        // wlast on beat 1 of a 4-beat burst.
        chk1("proto_err_clean", proto_err, 1'b0);
        for (int i = 0; i < 4; i++) begin wbuf[i] = rand256(); sbuf[i] = '1; end
        wr_burst(64'h300, 3, 1, -1, 1'b0);
        chk1("proto_err_set", proto_err, 1'b1);
        wr_burst(64'h300, 0, -1, -1, 1'b0);
        chk1("proto_err_sticky", proto_err, 1'b1);

        // Reset in the middle of an 8-beat write.
        for (int i = 0; i < 8; i++) begin wbuf[i] = rand256(); sbuf[i] = '1; end
        a0 = wbuf[0]; a1 = wbuf[1];
        wr_burst(64'h400, 7, -1, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin wbuf[i] = rand256(); sbuf[i] = '1; end
        wr_burst(64'h500, 3, -1, -1, 1'b0);
        rd_burst(64'h400, 1, 0);
        chkw("abort_beat0", rcap[0], a0);
        chkw("abort_beat1", rcap[1], a1);

        // Randomised traffic against the model, after making every word known.
        for (int i = 0; i < 64; i++) begin wbuf[i] = rand256(); sbuf[i] = '1; end
        wr_burst(64'h0, 63, -1, -1, 1'b1);
        for (int n = 0; n < 30; n++) begin
            logic [63:0] addr;
            int len;
            addr = {$urandom, $urandom};
            len  = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin
                    wbuf[i] = rand256();
                    sbuf[i] = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
                end
                wr_burst(addr, len, -1, -1, 1'b1);
            end else begin
                rd_burst(addr, len, 2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

- Synthesizable AXI4-style slave memory; the responder end of the `npu_top` `m_axi_*` master port.
- Accepts INCR write and read bursts of 256-bit beats and stores them in an internal word array.
- Sits in place of a behavioural memory model, for FPGA/emulation bring-up and for self-contained shell regressions.
- Write and read channels run independently; each carries one outstanding burst.

## Interface
- `ADDR_W`, 64, address width of `awaddr`/`araddr`
- `DATA_W`, 256, beat width; fixed 32-byte beats
- `MEM_BYTES`, 2097152, storage size in bytes; power of two, ≥ 64
- `clk` input 1 single clock, rising edge
- `rst_n` input 1 asynchronous active-low reset
- `s_axi_awvalid` input 1 write address valid
- `s_axi_awready` output 1 write address accept
- `s_axi_awaddr` input ADDR_W burst start byte address
- `s_axi_awlen` input 8 beats minus one
- `s_axi_awsize` input 3 beat size code; ignored, beats always 32 B
- `s_axi_wvalid` input 1 write data valid
- `s_axi_wready` output 1 write data accept
- `s_axi_wdata` input DATA_W write beat
- `s_axi_wstrb` input DATA_W/8 byte enables; bit i covers byte i
- `s_axi_wlast` input 1 last write beat marker
- `s_axi_bvalid` output 1 write response valid
- `s_axi_bready` input 1 write response accept
- `s_axi_arvalid` input 1 read address valid
- `s_axi_arready` output 1 read address accept
- `s_axi_araddr` input ADDR_W burst start byte address
- `s_axi_arlen` input 8 beats minus one
- `s_axi_arsize` input 3 ignored, beats always 32 B
- `s_axi_rvalid` output 1 read data valid
- `s_axi_rready` input 1 read data accept
- `s_axi_rdata` output DATA_W read beat
- `s_axi_rlast` output 1 last read beat
- `proto_err` output 1 sticky: a `wlast` mismatch occurred

## Operation
- **Storage:** `MEM_BYTES/32` words; contents are not reset.
- **Word index:** `(addr[log2(MEM_BYTES)-1:5] + beat) mod depth`.
  - Address bits [4:0] are ignored.
  - Bits above `log2(MEM_BYTES)-1` are ignored, so addresses alias.
  - A burst running past the top word wraps to word 0.
- **Write FSM, W_IDLE:** `awready`=1. An AW handshake latches the start index and `awlen`, clears the beat counter, and moves to W_DATA.
- **Write FSM, W_DATA:** `wready`=1.
  - Each W handshake writes the bytes whose `wstrb` bit is set; the counter then increments.
  - The handshake where counter == len moves to W_RESP.
  - If `wlast` ≠ (counter == len) on any beat, `proto_err` sets. The burst length still follows `awlen`.
- **Write FSM, W_RESP:** `bvalid`=1 until `bready`, then W_IDLE.
- **Read FSM, R_IDLE:** `arready`=1. An AR handshake latches the index and `arlen` and moves to R_DATA.
- **Read FSM, R_DATA:** `rvalid`=1 and `rdata` holds the current beat; `rlast`=1 when counter == len.
  - On an R handshake the next beat is presented.
  - The final handshake returns to R_IDLE.
  - While `rready`=0, `rdata` and `rlast` hold stable.
- **Same word written and read in one cycle:** the read beat returns the pre-write data (read-first).
- `proto_err` clears only on reset.

## Timing
- **Reset values:** `awready`=1, `arready`=1, `wready`=0, `bvalid`=0, `rvalid`=0, `rlast`=0, `rdata`=0, `proto_err`=0. Both FSMs are in their IDLE state.
- **Reset mid-burst:** both FSMs return to IDLE immediately. Already-written beats persist; no B or R response is issued.
- **Write path:**
  - AW handshake at edge N → `wready`=1 from cycle N+1.
  - Last W handshake at edge M → `bvalid`=1 in cycle M+1.
  - B handshake at edge K → `awready`=1 in cycle K+1.
- **Read path:**
  - AR handshake at edge N → `rvalid`=1 with the first beat in cycle N+1 (synchronous memory read).
  - With `rready` held high, one beat per cycle.
  - Last R handshake at edge K → `rvalid`=0 and `arready`=1 in cycle K+1.
- `awready`/`arready` are 0 throughout an active burst on their channel.
- `wvalid` arriving before AW is accepted is not consumed (`wready`=0).

## Test plan
- **Write then read:** AW addr 0x0, len 7; 8 beats of pattern i; then AR addr 0x0, len 7 → `rdata` beats equal the written beats. `rlast` only on beat 7. One `bvalid` pulse.
- **Strobes:** write word 3 all 0xFF; then write `wstrb`=0x0000_000F with data 0 → read word 3 gives bytes 0–3 = 0x00 and bytes 4–31 = 0xFF.
- **Back-pressure:** read len 3 with `rready` toggling 1,0,0,1,… → each beat is held stable while stalled. Exactly 4 handshakes occur, in order; `arready`=0 until after the last.
- **Wrap/alias:** `MEM_BYTES`=64, write at addr 0x20 with len 1 → the second beat lands in word 0. A read at 0x1000 returns word 0.
- **Protocol error:** len 3 with `wlast` asserted on beat 1 → `proto_err`=1. Four beats are still accepted, then `bvalid`.
- **Reset mid-burst:** drop `rst_n` after 2 of 8 write beats → all outputs take their reset values. A new burst completes normally, and beats 0–1 of the aborted burst read back as written.
